serial_link_credit_ctrl: RTL and testbench

Credit-based flow control stage between the network layer and the data link layer of the serial link. On TX, it forwards payload words to the data link only when remote credits are available. Each outgoing packet carries piggybacked credit returns; when the return backlog is high, it sends a credit-only packet instead. On RX, it buffers incoming payload in a receive FIFO sized to the credit count, harvests returned credits from incoming packets, and counts local pops as credits to return.

---
 rtl/serial_link_credit_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_serial_link_credit_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_credit_ctrl.sv
// serial_link_credit_ctrl: credit-based flow control between network and
// data link layers of the serial link.
//
// Ports:
//   clk_i, rst_ni, clear_i         clock, async active-low reset, sync clear
//   data_in_*                      TX payload from network layer (valid/ready)
//   data_out_*                     RX payload to network layer (FWFT FIFO head)
//   link_out_*                     packets to data link (registered, valid/ready)
//   link_in_*                      packets from data link (valid/ready)
//   credits_avail_o                remote credits available for TX data
//   credits_to_return_o            local pops not yet returned to remote
//
// Packet layout: {credit_only, credits[CntW-1:0], data[DataWidth-1:0]}.
// Optional macro SERIAL_LINK_CREDIT_TIMEOUT_EN adds an idle timeout that
// flushes a small credit backlog with a credit-only packet.
module serial_link_credit_ctrl #(
    parameter int DataWidth       = 64,
    parameter int NumCredits      = 8,
    parameter int ForceSendThresh = 6,
    parameter int TimeoutCycles   = 64,
    localparam int CntW           = $clog2(NumCredits + 1),
    localparam int PktW           = 1 + CntW + DataWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [DataWidth-1:0] data_in_i,
    input  logic                 data_in_valid_i,
    output logic                 data_in_ready_o,
    output logic [DataWidth-1:0] data_out_o,
    output logic                 data_out_valid_o,
    input  logic                 data_out_ready_i,
    output logic [PktW-1:0]      link_out_o,
    output logic                 link_out_valid_o,
    input  logic                 link_out_ready_i,
    input  logic [PktW-1:0]      link_in_i,
    input  logic                 link_in_valid_i,
    output logic                 link_in_ready_o,
    output logic [CntW-1:0]      credits_avail_o,
    output logic [CntW-1:0]      credits_to_return_o
);

    localparam int PtrW = $clog2(NumCredits);
    localparam logic [CntW:0]   MaxW    = (CntW + 1)'(NumCredits);
    localparam logic [CntW-1:0] MaxC    = CntW'(NumCredits);
    localparam logic [CntW-1:0] Thresh  = CntW'(ForceSendThresh);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NumCredits - 1);

    typedef enum logic {OutEmpty, OutFull} out_state_e;

    out_state_e           r_state;
    out_state_e           w_state_nxt;
    logic [PktW-1:0]      r_pkt;
    logic [PktW-1:0]      w_pkt_nxt;
    logic [CntW-1:0]      r_tx_credits;
    logic [CntW-1:0]      r_rx_return;
    logic [DataWidth-1:0] r_mem [NumCredits];
    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [CntW-1:0]      r_fifo_cnt;

    logic                 w_out_hs;
    logic                 w_load_ok;
    logic                 w_load_data;
    logic                 w_load_force;
    logic                 w_load;
    logic                 w_timeout;
    logic                 w_in_co;
    logic [CntW-1:0]      w_in_cr;
    logic [DataWidth-1:0] w_in_data;
    logic                 w_in_hs;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic [CntW:0]        w_tx_sum;
    logic [CntW:0]        w_rx_sum;

    assign w_in_co   = link_in_i[PktW-1];
    assign w_in_cr   = link_in_i[DataWidth +: CntW];
    assign w_in_data = link_in_i[DataWidth-1:0];

    // Load slot exists when empty, or when the held packet leaves this cycle.
    assign w_out_hs  = (r_state == OutFull) && link_out_ready_i;
    assign w_load_ok = !clear_i && ((r_state == OutEmpty) || w_out_hs);

    assign data_in_ready_o = w_load_ok && (r_tx_credits != '0);
    assign w_load_data     = data_in_valid_i && data_in_ready_o;
    // Credit-only packets need no credit, so returns flow even at zero credit.
    assign w_load_force    = w_load_ok && !w_load_data &&
                             ((r_rx_return >= Thresh) || w_timeout);
    assign w_load          = w_load_data || w_load_force;

    assign w_pkt_nxt = w_load_data ?
                       {1'b0, r_rx_return, data_in_i} :
                       {1'b1, r_rx_return, {DataWidth{1'b0}}};

`ifdef SERIAL_LINK_CREDIT_TIMEOUT_EN
    localparam int IdlW = $clog2(TimeoutCycles + 1);
    localparam logic [IdlW-1:0] IdlMax = IdlW'(TimeoutCycles);

    logic [IdlW-1:0] r_idle;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idle <= '0;
        end else if (clear_i || w_load) begin
            r_idle <= '0;
        end else if ((r_rx_return != '0) && (r_idle != IdlMax)) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign w_timeout = (r_idle == IdlMax) && (r_rx_return != '0);
`else
    assign w_timeout = 1'b0;
`endif

    // Output register FSM: state register / next state / outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= OutEmpty;
        end else if (clear_i) begin
            r_state <= OutEmpty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            OutEmpty: if (w_load) w_state_nxt = OutFull;
            OutFull:  if (w_out_hs && !w_load) w_state_nxt = OutEmpty;
            default:  w_state_nxt = OutEmpty;
        endcase
    end

    always_comb begin
        link_out_valid_o = (r_state == OutFull);
        link_out_o       = r_pkt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pkt <= '0;
        end else if (clear_i) begin
            r_pkt <= '0;
        end else if (w_load) begin
            r_pkt <= w_pkt_nxt;
        end else if (w_out_hs) begin
            r_pkt <= '0;
        end
    end

    // RX FIFO, first-word fall-through.
    assign w_fifo_full      = (r_fifo_cnt == MaxC);
    assign link_in_ready_o  = !clear_i && (w_in_co || !w_fifo_full);
    assign w_in_hs          = link_in_valid_i && link_in_ready_o;
    assign w_push           = w_in_hs && !w_in_co;
    assign data_out_valid_o = (r_fifo_cnt != '0);
    assign data_out_o       = r_mem[r_rptr];
    assign w_pop            = data_out_valid_o && data_out_ready_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_in_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else if (clear_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == LastIdx) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == LastIdx) ? '0 : r_rptr + 1'b1;
            r_fifo_cnt <= r_fifo_cnt + CntW'(w_push) - CntW'(w_pop);
        end
    end

    // Credit counters: all same-cycle events fold into one update.
    assign w_tx_sum = {1'b0, r_tx_credits}
                    + (w_in_hs ? {1'b0, w_in_cr} : '0)
                    - {{CntW{1'b0}}, w_load_data};
    // The load captures the whole backlog; a same-cycle pop stays.
    assign w_rx_sum = (w_load ? '0 : {1'b0, r_rx_return})
                    + {{CntW{1'b0}}, w_pop};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_credits <= MaxC;
            r_rx_return  <= '0;
        end else if (clear_i) begin
            r_tx_credits <= MaxC;
            r_rx_return  <= '0;
        end else begin
            r_tx_credits <= (w_tx_sum > MaxW) ? MaxC : w_tx_sum[CntW-1:0];
            r_rx_return  <= (w_rx_sum > MaxW) ? MaxC : w_rx_sum[CntW-1:0];
        end
    end

    assign credits_avail_o     = r_tx_credits;
    assign credits_to_return_o = r_rx_return;

    // Overflow means the remote returned more than it was granted.
    a_params: assert property (@(posedge clk_i)
        NumCredits >= 2 && ForceSendThresh >= 1 &&
        ForceSendThresh <= NumCredits && TimeoutCycles >= 1);
    a_tx_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
        clear_i || w_tx_sum <= MaxW);
    a_rx_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
        clear_i || w_rx_sum <= MaxW);
    a_tx_bnd: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_tx_credits <= MaxC);
    a_rx_bnd: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_rx_return <= MaxC);

endmodule

// File: tb/tb_serial_link_credit_ctrl.sv
// tb_serial_link_credit_ctrl: directed vector bench for the credit controller.
// Table vectors plus hand sequences for FIFO full, clear and async reset.
module tb_serial_link_credit_ctrl;

    localparam int DW = 64;
    localparam int CW = 4;
    localparam int PW = 69;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
    localparam logic [PW-1:0] Z  = '0;
    localparam logic [DW-1:0] D0 = '0;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic [DW-1:0] data_in_i = '0;
    logic          data_in_valid_i = 1'b0;
    logic          data_in_ready_o;
    logic [DW-1:0] data_out_o;
    logic          data_out_valid_o;
    logic          data_out_ready_i = 1'b0;
    logic [PW-1:0] link_out_o;
    logic          link_out_valid_o;
    logic          link_out_ready_i = 1'b0;
    logic [PW-1:0] link_in_i = '0;
    logic          link_in_valid_i = 1'b0;
    logic          link_in_ready_o;
    logic [CW-1:0] credits_avail_o;
    logic [CW-1:0] credits_to_return_o;

    serial_link_credit_ctrl dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .clear_i             (clear_i),
        .data_in_i           (data_in_i),
        .data_in_valid_i     (data_in_valid_i),
        .data_in_ready_o     (data_in_ready_o),
        .data_out_o          (data_out_o),
        .data_out_valid_o    (data_out_valid_o),
        .data_out_ready_i    (data_out_ready_i),
        .link_out_o          (link_out_o),
        .link_out_valid_o    (link_out_valid_o),
        .link_out_ready_i    (link_out_ready_i),
        .link_in_i           (link_in_i),
        .link_in_valid_i     (link_in_valid_i),
        .link_in_ready_o     (link_in_ready_o),
        .credits_avail_o     (credits_avail_o),
        .credits_to_return_o (credits_to_return_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dv;
        logic [DW-1:0] d;
        logic          lr;
        logic          iv;
        logic [PW-1:0] il;
        logic          dr;
        logic          e_rdy;
        logic          e_lv;
        logic [PW-1:0] e_lo;
        logic          e_dv;
        logic [DW-1:0] e_do;
        logic [CW-1:0] e_cav;
        logic [CW-1:0] e_ctr;
    } vec_t;

    vec_t vt[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [PW-1:0] pk(input logic co,
                                         input logic [CW-1:0] cr,
                                         input logic [DW-1:0] d);
        return {co, cr, d};
    endfunction

    function automatic logic [DW-1:0] w(input int k);
        return 64'h100 + 64'(k);
    endfunction

    function automatic void add(
        input logic dv, input logic [DW-1:0] d, input logic lr,
        input logic iv, input logic [PW-1:0] il, input logic dr,
        input logic er, input logic ev, input logic [PW-1:0] el,
        input logic edv, input logic [DW-1:0] ed,
        input logic [CW-1:0] ec, input logic [CW-1:0] et);
        vec_t v;
        v.dv = dv; v.d = d; v.lr = lr; v.iv = iv; v.il = il; v.dr = dr;
        v.e_rdy = er; v.e_lv = ev; v.e_lo = el; v.e_dv = edv;
        v.e_do = ed; v.e_cav = ec; v.e_ctr = et;
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        data_in_valid_i  = 1'b0;
        data_in_i        = '0;
        link_in_valid_i  = 1'b0;
        link_in_i        = '0;
        data_out_ready_i = 1'b0;
        link_out_ready_i = 1'b0;
        clear_i          = 1'b0;
    endtask

    initial begin
        // Reset then idle.
        add(O, D0, I, O, Z, O, I, O, Z, O, D0, 4'd8, 4'd0);
        // Nine TX words against eight credits.
        for (int i = 0; i < 9; i++)
            add(I, w(i), I, O, Z, O, i < 8, i >= 1,
                (i >= 1) ? pk(O, 4'd0, w(i - 1)) : Z, O, D0,
                4'(8 - i), 4'd0);
        add(I, w(8), I, O, Z, O, O, O, Z, O, D0, 4'd0, 4'd0);
        // Credit-only return of 3, then three more words and a stall.
        add(I, w(8), I, I, pk(I, 4'd3, D0), O, O, O, Z, O, D0, 4'd0, 4'd0);
        add(I, w(8), I, O, Z, O, I, O, Z, O, D0, 4'd3, 4'd0);
        add(I, w(9), I, O, Z, O, I, I, pk(O, 4'd0, w(8)), O, D0, 4'd2, 4'd0);
        add(I, w(10), I, O, Z, O, I, I, pk(O, 4'd0, w(9)), O, D0, 4'd1, 4'd0);
        add(I, w(11), I, O, Z, O, O, I, pk(O, 4'd0, w(10)), O, D0, 4'd0, 4'd0);
        add(I, w(11), I, O, Z, O, O, O, Z, O, D0, 4'd0, 4'd0);
        // Six RX words, popped in order, threshold forces a return.
        add(O, D0, I, I, pk(O, 4'd0, 64'hA0), I, O, O, Z, O, D0, 4'd0, 4'd0);
        for (int k = 1; k < 6; k++)
            add(O, D0, I, I, pk(O, 4'd0, 64'hA0 + 64'(k)), I, O, O, Z,
                I, 64'hA0 + 64'(k - 1), 4'd0, 4'(k - 1));
        add(O, D0, I, O, Z, I, O, O, Z, I, 64'hA5, 4'd0, 4'd5);
        add(O, D0, I, O, Z, I, O, O, Z, O, D0, 4'd0, 4'd6);
        add(O, D0, I, O, Z, I, O, I, pk(I, 4'd6, D0), O, D0, 4'd0, 4'd0);
        add(O, D0, I, O, Z, O, O, O, Z, O, D0, 4'd0, 4'd0);
        // Piggyback of backlog 2 with a same-cycle pop.
        add(O, D0, I, I, pk(I, 4'd4, D0), O, O, O, Z, O, D0, 4'd0, 4'd0);
        add(O, D0, I, I, pk(O, 4'd0, 64'hB0), O, I, O, Z, O, D0, 4'd4, 4'd0);
        add(O, D0, I, I, pk(O, 4'd0, 64'hB1), I, I, O, Z, I, 64'hB0, 4'd4, 4'd0);
        add(O, D0, I, I, pk(O, 4'd0, 64'hB2), I, I, O, Z, I, 64'hB1, 4'd4, 4'd1);
        add(I, 64'h55, I, O, Z, I, I, O, Z, I, 64'hB2, 4'd4, 4'd2);
        add(O, D0, I, O, Z, O, I, I, pk(O, 4'd2, 64'h55), O, D0, 4'd3, 4'd1);
        // Backpressure holds the packet; return + load in one cycle.
        add(I, 64'h77, O, O, Z, O, I, O, Z, O, D0, 4'd3, 4'd1);
        for (int k = 0; k < 5; k++)
            add(I, 64'h78, O, O, Z, O, O, I, pk(O, 4'd1, 64'h77),
                O, D0, 4'd2, 4'd0);
        add(I, 64'h78, I, I, pk(I, 4'd2, D0), O, I, I, pk(O, 4'd1, 64'h77),
            O, D0, 4'd2, 4'd0);
        add(O, D0, I, O, Z, O, I, I, pk(O, 4'd0, 64'h78), O, D0, 4'd3, 4'd0);
        add(O, D0, I, O, Z, O, I, O, Z, O, D0, 4'd3, 4'd0);

        idle_in();
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        #2;
        chk("rst.lout", link_out_o, Z);
        chk("rst.lv", PW'(link_out_valid_o), Z);

        for (int i = 0; i < vt.size(); i++) begin
            data_in_valid_i  = vt[i].dv;
            data_in_i        = vt[i].d;
            link_out_ready_i = vt[i].lr;
            link_in_valid_i  = vt[i].iv;
            link_in_i        = vt[i].il;
            data_out_ready_i = vt[i].dr;
            #3;
            chk($sformatf("v%0d.rdy", i), PW'(data_in_ready_o), PW'(vt[i].e_rdy));
            chk($sformatf("v%0d.lv", i), PW'(link_out_valid_o), PW'(vt[i].e_lv));
            if (vt[i].e_lv)
                chk($sformatf("v%0d.lout", i), link_out_o, vt[i].e_lo);
            chk($sformatf("v%0d.dv", i), PW'(data_out_valid_o), PW'(vt[i].e_dv));
            if (vt[i].e_dv)
                chk($sformatf("v%0d.dout", i), PW'(data_out_o), PW'(vt[i].e_do));
            chk($sformatf("v%0d.cav", i), PW'(credits_avail_o), PW'(vt[i].e_cav));
            chk($sformatf("v%0d.ctr", i), PW'(credits_to_return_o), PW'(vt[i].e_ctr));
            @(posedge clk);
            #1;
        end

        // Fill the RX FIFO while a packet is held; then clear.
        idle_in();
        for (int i = 0; i < 8; i++) begin
            data_in_valid_i = (i == 0);
            data_in_i       = 64'h99;
            link_in_valid_i = 1'b1;
            link_in_i       = pk(O, 4'd0, 64'hC0 + 64'(i));
            @(posedge clk);
            #1;
        end
        data_in_valid_i = 1'b0;
        link_in_i       = pk(O, 4'd0, 64'hC8);
        #1;
        chk("full.irdy_data", PW'(link_in_ready_o), Z);
        chk("full.dv", PW'(data_out_valid_o), PW'(1));
        chk("full.dout", PW'(data_out_o), PW'(64'hC0));
        chk("full.lout", link_out_o, pk(O, 4'd0, 64'h99));
        chk("full.cav", PW'(credits_avail_o), PW'(2));
        link_in_i = pk(I, 4'd0, D0);
        #1;
        chk("full.irdy_co", PW'(link_in_ready_o), PW'(1));
        clear_i          = 1'b1;
        link_in_i        = pk(I, 4'd2, D0);
        data_in_valid_i  = 1'b1;
        link_out_ready_i = 1'b1;
        data_out_ready_i = 1'b1;
        @(posedge clk);
        #1 idle_in();
        #1;
        chk("clr.cav", PW'(credits_avail_o), PW'(8));
        chk("clr.ctr", PW'(credits_to_return_o), Z);
        chk("clr.dv", PW'(data_out_valid_o), Z);
        chk("clr.lv", PW'(link_out_valid_o), Z);
        chk("clr.lout", link_out_o, Z);
        chk("clr.irdy", PW'(link_in_ready_o), PW'(1));

        // Asynchronous reset discards an in-flight packet.
        @(posedge clk);
        #1;
        data_in_valid_i = 1'b1;
        data_in_i       = 64'hAB;
        @(posedge clk);
        #1 data_in_valid_i = 1'b0;
        chk("hold.lout", link_out_o, pk(O, 4'd0, 64'hAB));
        chk("hold.cav", PW'(credits_avail_o), PW'(7));
        #1 rst_ni = 1'b0;
        #1;
        chk("arst.lv", PW'(link_out_valid_o), Z);
        chk("arst.lout", link_out_o, Z);
        chk("arst.cav", PW'(credits_avail_o), PW'(8));
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("post.lv", PW'(link_out_valid_o), Z);
        chk("post.cav", PW'(credits_avail_o), PW'(8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
